// File: rtl/tdc_launch_seq_if.sv
// Port bundle for the TDC launch sequencer: master is the burst requester, slave is the sequencer.
// The abort signal exists only when TDC_LAUNCH_SEQ_ABORT_EN is defined.
interface tdc_launch_seq_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 8
);
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic [GAP_W-1:0] gap;
    logic             mode;
`ifdef TDC_LAUNCH_SEQ_ABORT_EN
    logic             abort;
`endif
    logic             pg_en;
    logic             pg_in;
    logic             pg_tog;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] launch_cnt;

    modport master (
`ifdef TDC_LAUNCH_SEQ_ABORT_EN
        output abort,
`endif
        output start, burst_len, gap, mode,
        input  pg_en, pg_in, pg_tog, busy, done, launch_cnt
    );

    modport slave (
`ifdef TDC_LAUNCH_SEQ_ABORT_EN
        input  abort,
`endif
        input  start, burst_len, gap, mode,
        output pg_en, pg_in, pg_tog, busy, done, launch_cnt
    );
endinterface

// File: rtl/tdc_launch_seq.sv
// Launch sequencer driving the TDC pulse-generator stage with a programmed burst of launch edges.
// Optional abort input enabled by defining TDC_LAUNCH_SEQ_ABORT_EN.
module tdc_launch_seq #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 8
) (
    input  logic            clk_launch,
    input  logic            rst,
    tdc_launch_seq_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_LAUNCH, S_GAP, S_DONE} state_t;

    state_t           r_state,      w_state_nxt;
    logic [CNT_W-1:0] r_burst_len,  w_burst_len_nxt;
    logic [GAP_W-1:0] r_gap,        w_gap_nxt;
    logic             r_mode,       w_mode_nxt;
    logic [CNT_W-1:0] r_launch_cnt, w_launch_cnt_nxt;
    logic [GAP_W-1:0] r_gap_cnt,    w_gap_cnt_nxt;
    logic             r_pg_en,      w_pg_en_nxt;
    logic             r_pg_in,      w_pg_in_nxt;
    logic             r_pg_tog,     w_pg_tog_nxt;
    logic             r_busy,       w_busy_nxt;
    logic             r_done,       w_done_nxt;

    logic             w_abort;
    logic [GAP_W-1:0] w_eff_gap;
    logic [CNT_W-1:0] w_cnt_inc;

`ifdef TDC_LAUNCH_SEQ_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    // Pulse mode needs at least one gap cycle so pg_in drops between launches.
    assign w_eff_gap = (!r_mode && r_gap == '0) ? GAP_W'(1) : r_gap;
    assign w_cnt_inc = r_launch_cnt + CNT_W'(1);

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can infer a latch.
        w_state_nxt      = r_state;
        w_burst_len_nxt  = r_burst_len;
        w_gap_nxt        = r_gap;
        w_mode_nxt       = r_mode;
        w_launch_cnt_nxt = r_launch_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_burst_len_nxt  = bus.burst_len;
                    w_gap_nxt        = bus.gap;
                    w_mode_nxt       = bus.mode;
                    w_launch_cnt_nxt = '0;
                    w_state_nxt      = S_ARM;
                end
            end
            // A zero-length burst spends this cycle with pg_en low, then finishes without launching.
            S_ARM:    w_state_nxt = (r_burst_len == '0) ? S_DONE : S_LAUNCH;
            S_LAUNCH: begin
                w_launch_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == r_burst_len) begin
                    w_state_nxt = S_DONE;
                end else if (w_eff_gap == '0) begin
                    w_state_nxt = S_LAUNCH;
                end else begin
                    w_state_nxt   = S_GAP;
                    w_gap_cnt_nxt = w_eff_gap;
                end
            end
            S_GAP: begin
                w_gap_cnt_nxt = (r_gap_cnt == '0) ? '0 : r_gap_cnt - GAP_W'(1);
                if (r_gap_cnt <= GAP_W'(1)) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase

        if (w_abort && (r_state inside {S_ARM, S_LAUNCH, S_GAP})) begin
            w_state_nxt = S_DONE;
        end

        // Outputs are decoded from the next state so they come straight out of flops.
        w_busy_nxt   = w_state_nxt inside {S_ARM, S_LAUNCH, S_GAP};
        w_pg_en_nxt  = w_busy_nxt && (w_burst_len_nxt != '0);
        w_done_nxt   = (w_state_nxt == S_DONE);
        w_pg_in_nxt  = (w_state_nxt == S_LAUNCH) && !w_mode_nxt;
        w_pg_tog_nxt = ((w_state_nxt == S_LAUNCH) && w_mode_nxt) ? ~r_pg_tog : r_pg_tog;
    end

    always_ff @(posedge clk_launch) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_burst_len  <= '0;
            r_gap        <= '0;
            r_mode       <= 1'b0;
            r_launch_cnt <= '0;
            r_gap_cnt    <= '0;
            r_pg_en      <= 1'b0;
            r_pg_in      <= 1'b0;
            r_pg_tog     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values.
            r_state      <= w_state_nxt;
            r_burst_len  <= w_burst_len_nxt;
            r_gap        <= w_gap_nxt;
            r_mode       <= w_mode_nxt;
            r_launch_cnt <= w_launch_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_pg_en      <= w_pg_en_nxt;
            r_pg_in      <= w_pg_in_nxt;
            r_pg_tog     <= w_pg_tog_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.pg_en      = r_pg_en;
    assign bus.pg_in      = r_pg_in;
    assign bus.pg_tog     = r_pg_tog;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.launch_cnt = r_launch_cnt;
endmodule
